// File: rtl/fetch_ctrl_if.sv
// Fetch controller bundle: instruction memory port, redirect/halt control, decode handshake.
// Latency: none, wires only.
// Backpressure: out_ready from decode stalls the fetch buffer head.
interface fetch_ctrl_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic        misalign_err;

  // Fetch controller side.
  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    input  halt_req,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output halted,
    output misalign_err
  );

  // Environment side: memory, branch unit and decode.
  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    output halt_req,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  halted,
    input  misalign_err
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC register, 2-entry {pc,instr} buffer, RUN/HALT FSM.
// Latency: 1 cycle from fetch edge to out_valid; redirect costs one flush cycle.
// Backpressure: out_ready=0 holds the head; fetch stalls once the buffer holds 2 entries.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic          Clk,
  input  logic          reset,
  fetch_ctrl_if.master  bus
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic        misalign_q;

  logic        out_valid;
  logic        pop;
  logic        fetch;
  logic        redirect_bad;

  // Redirect hides the buffer in the flush cycle so stale entries never reach decode.
  assign out_valid = (count != 2'd0) && !bus.redirect_valid;

  assign bus.imem_addr    = pc_q;
  assign bus.out_valid    = out_valid;
  assign bus.out_pc       = buf_pc[rd_ptr];
  assign bus.out_instr    = buf_instr[rd_ptr];
  assign bus.halted       = (state_q == HALT) && (count == 2'd0);
  assign bus.misalign_err = misalign_q;

  // Next state plus per-cycle fetch/pop decisions.
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    fetch        = 1'b0;
    redirect_bad = 1'b0;
    unique case (state_q)
      RUN:  if (bus.halt_req)  state_d = HALT;
      HALT: if (!bus.halt_req) state_d = RUN;
    endcase
    pop          = out_valid && bus.out_ready;
    // A full buffer may still fetch when the head leaves in the same cycle.
    fetch        = (state_q == RUN) && !bus.halt_req && !bus.redirect_valid &&
                   ((count != 2'd2) || pop);
    redirect_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Fetch PC: redirect wins over sequential advance; misaligned targets go to the trap vector.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else if (bus.redirect_valid) begin
      pc_q <= redirect_bad ? TRAP_VEC : bus.redirect_pc;
    end else if (fetch) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  // Buffer pointers and occupancy; redirect flushes everything.
  always_ff @(posedge Clk) begin
    if (!reset || bus.redirect_valid) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (fetch) wr_ptr <= ~wr_ptr;
      if (pop)   rd_ptr <= ~rd_ptr;
      if (fetch && !pop)      count <= count + 2'd1;
      else if (!fetch && pop) count <= count - 2'd1;
    end
  end

  // Buffer storage; contents are only meaningful below count, so no reset needed.
  always_ff @(posedge Clk) begin
    if (fetch) begin
      buf_pc[wr_ptr]    <= pc_q;
      buf_instr[wr_ptr] <= bus.imem_data;
    end
  end

  // One-cycle registered pulse for a misaligned redirect target.
  always_ff @(posedge Clk) begin
    if (!reset) misalign_q <= 1'b0;
    else        misalign_q <= redirect_bad;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: scoreboard of expected fetch PCs checked on every accepted output.
// Latency: checks assume 1-cycle fetch-to-output.
// Backpressure: out_ready is driven per scenario to exercise stalls.
module tb_fetch_ctrl;

  logic Clk = 1'b0;
  logic reset;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .RESET_PC(32'h0000_0000),
    .TRAP_VEC(32'h0000_0100)
  ) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Instruction memory image: a distinct word per address.
  function automatic logic [31:0] imem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  assign bus.imem_data = imem_fn(bus.imem_addr);

  int          n_checks = 0;
  int          n_errs   = 0;
  logic [31:0] sb [$];
  logic [31:0] mon_exp;
  bit          mon_en = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Every handshake that the next rising edge will commit is scored against the queue.
  always @(negedge Clk) begin
    if (mon_en && reset === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      check_val("sb_has_entry", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        check_val("out_pc", bus.out_pc, mon_exp);
        check_val("out_instr", bus.out_instr, imem_fn(mon_exp));
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One reset edge with quiet inputs, then release with the given ready level.
  task automatic start(input logic ready);
    reset              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.halt_req       = 1'b0;
    bus.out_ready      = 1'b0;
    sb.delete();
    tick();
    reset         = 1'b1;
    bus.out_ready = ready;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset wins over a simultaneous halt and misaligned redirect.
    reset              = 1'b0;
    bus.halt_req       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h42;
    bus.out_ready      = 1'b1;
    tick();
    tick();
    check_val("rst_misalign", {31'b0, bus.misalign_err}, 32'd0);
    check_val("rst_halted", {31'b0, bus.halted}, 32'd0);
    check_val("rst_imem_addr", bus.imem_addr, 32'h0);
    bus.redirect_valid = 1'b0;
    bus.halt_req       = 1'b0;
    #1;
    check_val("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    mon_en = 1'b1;

    // Free-running stream from reset.
    start(1'b1);
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8); sb.push_back(32'hC);
    tick();
    check_val("first_out_valid", {31'b0, bus.out_valid}, 32'd1);
    repeat (4) tick();
    check_val("stream_drained", 32'(sb.size()), 32'd0);

    // Stall: buffer fills to two, head holds, then drains without a gap.
    start(1'b0);
    repeat (5) tick();
    check_val("stall_out_valid", {31'b0, bus.out_valid}, 32'd1);
    check_val("stall_out_pc", bus.out_pc, 32'h0);
    check_val("stall_imem_addr", bus.imem_addr, 32'h8);
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    check_val("stall_drained", 32'(sb.size()), 32'd0);

    // Aligned redirect with a full buffer flushes stale entries.
    start(1'b0);
    repeat (2) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    bus.out_ready      = 1'b1;
    #1;
    check_val("redir_out_valid", {31'b0, bus.out_valid}, 32'd0);
    sb.push_back(32'h40); sb.push_back(32'h44);
    tick();
    bus.redirect_valid = 1'b0;
    check_val("redir_misalign", {31'b0, bus.misalign_err}, 32'd0);
    check_val("redir_imem_addr", bus.imem_addr, 32'h40);
    repeat (3) tick();
    check_val("redir_drained", 32'(sb.size()), 32'd0);

    // Misaligned redirect traps and pulses misalign_err once.
    start(1'b0);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h42;
    bus.out_ready      = 1'b1;
    sb.push_back(32'h100); sb.push_back(32'h104);
    tick();
    bus.redirect_valid = 1'b0;
    check_val("mis_pulse", {31'b0, bus.misalign_err}, 32'd1);
    check_val("mis_imem_addr", bus.imem_addr, 32'h100);
    tick();
    check_val("mis_pulse_end", {31'b0, bus.misalign_err}, 32'd0);
    repeat (2) tick();
    check_val("mis_drained", 32'(sb.size()), 32'd0);

    // Halt with a full buffer: drain two, freeze, then resume at the frozen PC.
    start(1'b0);
    repeat (2) tick();
    bus.halt_req  = 1'b1;
    bus.out_ready = 1'b1;
    sb.push_back(32'h0); sb.push_back(32'h4);
    tick();
    check_val("halt_draining", {31'b0, bus.halted}, 32'd0);
    check_val("halt_head_valid", {31'b0, bus.out_valid}, 32'd1);
    tick();
    check_val("halt_halted", {31'b0, bus.halted}, 32'd1);
    check_val("halt_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check_val("halt_imem_addr", bus.imem_addr, 32'h8);
    repeat (2) tick();
    check_val("halt_frozen_addr", bus.imem_addr, 32'h8);
    check_val("halt_still", {31'b0, bus.halted}, 32'd1);
    bus.halt_req = 1'b0;
    sb.push_back(32'h8); sb.push_back(32'hC);
    tick();
    check_val("resume_halted", {31'b0, bus.halted}, 32'd0);
    repeat (3) tick();
    check_val("resume_drained", 32'(sb.size()), 32'd0);

    // PC wraps past the top of the address space.
    start(1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    sb.push_back(32'hFFFF_FFF8); sb.push_back(32'hFFFF_FFFC); sb.push_back(32'h0000_0000);
    tick();
    bus.redirect_valid = 1'b0;
    repeat (4) tick();
    check_val("wrap_drained", 32'(sb.size()), 32'd0);

    reset         = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
